// File: rtl/uart_pkg.sv
// Shared UART definitions: clock/baud defaults, receiver FSM states and
// remote-control command bytes used by both receiver and transmitter.
package uart_pkg;

   localparam int CLK_FREQ_DEF  = 65_000_000;
   localparam int BAUD_RATE_DEF = 9_600;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_IDLE = 3'd4
   } rx_state_e;

   localparam logic [7:0] CMD_UP   = 8'h41;
   localparam logic [7:0] CMD_DOWN = 8'h42;

   function automatic logic is_fall(input logic prev_v, input logic cur_v);
      return prev_v & ~cur_v;
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial line plus received-byte/command pulse bundle of the UART receiver.
// slave = the receiver, master = the line driver / byte consumer side.
interface uart_rx_if;
   logic       RxD;
   logic [7:0] data;
   logic       data_valid;
   logic       frame_err;
   logic       remote_up;
   logic       remote_down;

   modport slave (
      input  RxD,
      output data, data_valid, frame_err, remote_up, remote_down
   );

   modport master (
      output RxD,
      input  data, data_valid, frame_err, remote_up, remote_down
   );
endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input; resets to
// RST_VAL so an idle-high line does not look like an edge after reset.
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Two-stage resynchronization into the clk domain
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and registered one-cycle pulses.
// Define UART_RX_CMD_DECODE_EN to decode CMD_UP/CMD_DOWN into remote pulses.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = CLK_FREQ_DEF,
   parameter int BAUD_RATE = BAUD_RATE_DEF
) (
   input  logic     clk,
   input  logic     rst,
   uart_rx_if.slave bus
);

   localparam int BIT_CYCLES  = CLK_FREQ / BAUD_RATE;
   localparam int HALF_CYCLES = BIT_CYCLES / 2;
   localparam int CNT_W       = $clog2(BIT_CYCLES);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYCLES - 1);

   logic             rx_s;
   rx_state_e        state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       bit_idx_q;
   logic [7:0]       shreg_q;
   logic [7:0]       data_q;
   logic             rx_prev_q;
   logic             valid_q;
   logic             ferr_q;
`ifdef UART_RX_CMD_DECODE_EN
   logic             up_q;
   logic             down_q;
`endif

   sync_2ff #(.RST_VAL(1'b1)) u_sync (
      .clk (clk),
      .rst (rst),
      .d_i (bus.RxD),
      .q_o (rx_s)
   );

   // Frame FSM: bit timing, LSB-first shifting, stop check and output pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_idx_q <= 3'd0;
         shreg_q   <= 8'h00;
         data_q    <= 8'h00;
         rx_prev_q <= 1'b1;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
`ifdef UART_RX_CMD_DECODE_EN
         up_q      <= 1'b0;
         down_q    <= 1'b0;
`endif
      end else begin
         rx_prev_q <= rx_s;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
`ifdef UART_RX_CMD_DECODE_EN
         up_q      <= 1'b0;
         down_q    <= 1'b0;
`endif
         case (state_q)
            IDLE: begin
               cnt_q <= '0;
               if (is_fall(rx_prev_q, rx_s)) begin
                  state_q <= START;
               end else begin
                  state_q <= IDLE;
               end
            end
            START: begin
               if (cnt_q == HALF_LAST) begin
                  cnt_q     <= '0;
                  bit_idx_q <= 3'd0;
                  // A start bit that has gone high by mid-bit was a glitch
                  state_q   <= rx_s ? IDLE : DATA;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            DATA: begin
               if (cnt_q == BIT_LAST) begin
                  cnt_q     <= '0;
                  shreg_q   <= {rx_s, shreg_q[7:1]};
                  bit_idx_q <= bit_idx_q + 3'd1;
                  if (bit_idx_q == 3'd7) begin
                     state_q <= STOP;
                  end else begin
                     state_q <= DATA;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            STOP: begin
               if (cnt_q == BIT_LAST) begin
                  cnt_q <= '0;
                  if (rx_s) begin
                     data_q  <= shreg_q;
                     valid_q <= 1'b1;
`ifdef UART_RX_CMD_DECODE_EN
                     up_q    <= (shreg_q == CMD_UP);
                     down_q  <= (shreg_q == CMD_DOWN);
`endif
                     state_q <= IDLE;
                  end else begin
                     ferr_q  <= 1'b1;
                     state_q <= WAIT_IDLE;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            WAIT_IDLE: begin
               cnt_q <= '0;
               if (rx_s) begin
                  state_q <= IDLE;
               end else begin
                  state_q <= WAIT_IDLE;
               end
            end
            default: begin
               cnt_q   <= '0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.data       = data_q;
   assign bus.data_valid = valid_q;
   assign bus.frame_err  = ferr_q;
`ifdef UART_RX_CMD_DECODE_EN
   assign bus.remote_up   = up_q;
   assign bus.remote_down = down_q;
`else
   assign bus.remote_up   = 1'b0;
   assign bus.remote_down = 1'b0;
`endif

endmodule
